lsu_timeout: RTL and testbench

Parametrised per-thread load/store unit for the GPU core. It is the next generation of the existing LSU: address and data widths are configurable, and it adds a bounded wait timeout with automatic re-issue and an error state. It sits between the decoder/register file (rs = address, rt = store data) and the memory controller's per-channel valid/ready interface. It is sequenced by the core's 3-bit pipeline state.

---
 rtl/lsu_timeout.sv | 181 ++++++++++++++++++
 tb/tb_lsu_timeout.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/lsu_timeout.sv
// Per-thread load/store unit with a bounded wait on the memory handshake,
// automatic re-issue after a timeout, and an error state once retries run out.
module lsu_timeout #(
  parameter int ADDR_BITS   = 8,
  parameter int DATA_BITS   = 8,
  parameter int TIMEOUT     = 16,
  parameter int MAX_RETRIES = 2,
  localparam int RW         = $clog2(MAX_RETRIES + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [2:0]           core_state,
  input  logic                 decoded_mem_read_enable,
  input  logic                 decoded_mem_write_enable,
  input  logic [ADDR_BITS-1:0] rs,
  input  logic [DATA_BITS-1:0] rt,
  output logic                 mem_read_valid,
  output logic [ADDR_BITS-1:0] mem_read_addr,
  input  logic                 mem_read_ready,
  input  logic [DATA_BITS-1:0] mem_read_data,
  output logic                 mem_write_valid,
  output logic [ADDR_BITS-1:0] mem_write_addr,
  output logic [DATA_BITS-1:0] mem_write_data,
  input  logic                 mem_write_ready,
  output logic [DATA_BITS-1:0] lsu_out,
  output logic [2:0]           lsu_state,
  output logic                 lsu_error,
  output logic [RW-1:0]        lsu_retries
);

  localparam logic [2:0] CORE_REQUEST = 3'b011;
  localparam logic [2:0] CORE_UPDATE  = 3'b110;
  localparam int         CW           = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST  = CW'(TIMEOUT - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);

  typedef enum logic [2:0] {
    IDLE       = 3'b000,
    REQUESTING = 3'b001,
    WAITING    = 3'b010,
    DONE       = 3'b011,
    ERROR      = 3'b100
  } state_t;

  state_t               state, state_next;
  logic                 op, op_next;  // 1 = store, 0 = load
  logic [ADDR_BITS-1:0] addr, addr_next;
  logic [DATA_BITS-1:0] data, data_next;
  logic [CW-1:0]        cnt, cnt_next;
  logic                 rvalid, rvalid_next;
  logic                 wvalid, wvalid_next;
  logic [ADDR_BITS-1:0] raddr, raddr_next;
  logic [ADDR_BITS-1:0] waddr, waddr_next;
  logic [DATA_BITS-1:0] wdata, wdata_next;
  logic [DATA_BITS-1:0] out, out_next;
  logic                 err, err_next;
  logic [RW-1:0]        retries, retries_next;
  logic                 ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      op      <= 1'b0;
      addr    <= '0;
      data    <= '0;
      cnt     <= '0;
      rvalid  <= 1'b0;
      wvalid  <= 1'b0;
      raddr   <= '0;
      waddr   <= '0;
      wdata   <= '0;
      out     <= '0;
      err     <= 1'b0;
      retries <= '0;
    end else begin
      state   <= state_next;
      op      <= op_next;
      addr    <= addr_next;
      data    <= data_next;
      cnt     <= cnt_next;
      rvalid  <= rvalid_next;
      wvalid  <= wvalid_next;
      raddr   <= raddr_next;
      waddr   <= waddr_next;
      wdata   <= wdata_next;
      out     <= out_next;
      err     <= err_next;
      retries <= retries_next;
    end
  end

  // Only the channel of the latched op is listened to.
  assign ready = op ? mem_write_ready : mem_read_ready;

  always_comb begin
    state_next   = state;
    op_next      = op;
    addr_next    = addr;
    data_next    = data;
    cnt_next     = cnt;
    rvalid_next  = rvalid;
    wvalid_next  = wvalid;
    raddr_next   = raddr;
    waddr_next   = waddr;
    wdata_next   = wdata;
    out_next     = out;
    err_next     = err;
    retries_next = retries;
    case (state)
      IDLE: begin
        if (enable && core_state == CORE_REQUEST &&
            (decoded_mem_read_enable || decoded_mem_write_enable)) begin
          op_next    = !decoded_mem_read_enable;  // read wins when both set
          addr_next  = rs;
          data_next  = rt;
          state_next = REQUESTING;
        end
      end
      REQUESTING: begin
        if (op) begin
          wvalid_next = 1'b1;
          waddr_next  = addr;
          wdata_next  = data;
        end else begin
          rvalid_next = 1'b1;
          raddr_next  = addr;
        end
        cnt_next   = '0;
        state_next = WAITING;
      end
      WAITING: begin
        if (ready) begin
          rvalid_next = 1'b0;
          wvalid_next = 1'b0;
          if (!op) out_next = mem_read_data;
          state_next = DONE;
        end else if (cnt == CNT_LAST) begin
          rvalid_next = 1'b0;
          wvalid_next = 1'b0;
          if (retries < RETRY_MAX) begin
            retries_next = retries + 1'b1;
            state_next   = REQUESTING;
          end else begin
            err_next   = 1'b1;
            state_next = ERROR;
          end
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      DONE: begin
        if (core_state == CORE_UPDATE) begin
          retries_next = '0;
          state_next   = IDLE;
        end
      end
      ERROR: begin
        if (core_state == CORE_UPDATE) begin
          err_next     = 1'b0;
          retries_next = '0;
          state_next   = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    mem_read_valid  = rvalid;
    mem_read_addr   = raddr;
    mem_write_valid = wvalid;
    mem_write_addr  = waddr;
    mem_write_data  = wdata;
    lsu_out         = out;
    lsu_state       = state;
    lsu_error       = err;
    lsu_retries     = retries;
  end

endmodule

// File: tb/tb_lsu_timeout.sv
// Directed bench for lsu_timeout: load/store handshakes, timeout re-issue,
// retry exhaustion, ready-on-expiry, dual enables and asynchronous reset.
module tb_lsu_timeout;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [2:0] core_state;
  logic       rd_en, wr_en;
  logic [7:0] rs, rt;
  logic       mem_read_valid, mem_read_ready;
  logic [7:0] mem_read_addr, mem_read_data;
  logic       mem_write_valid, mem_write_ready;
  logic [7:0] mem_write_addr, mem_write_data;
  logic [7:0] lsu_out;
  logic [2:0] lsu_state;
  logic       lsu_error;
  logic [1:0] lsu_retries;

  int errors = 0;
  int checks = 0;
  int len;
  bit other_seen, chan_bad;

  localparam logic [2:0] REQ = 3'b011, UPD = 3'b110;
  localparam logic [2:0] S_IDLE = 3'd0, S_REQ = 3'd1, S_WAIT = 3'd2, S_DONE = 3'd3, S_ERR = 3'd4;

  lsu_timeout dut (
    .clk(clk), .reset(reset), .enable(enable), .core_state(core_state),
    .decoded_mem_read_enable(rd_en), .decoded_mem_write_enable(wr_en),
    .rs(rs), .rt(rt),
    .mem_read_valid(mem_read_valid), .mem_read_addr(mem_read_addr),
    .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
    .mem_write_valid(mem_write_valid), .mem_write_addr(mem_write_addr),
    .mem_write_data(mem_write_data), .mem_write_ready(mem_write_ready),
    .lsu_out(lsu_out), .lsu_state(lsu_state), .lsu_error(lsu_error),
    .lsu_retries(lsu_retries)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present an op in REQUEST for one edge; leaves the DUT in its first valid-high cycle.
  task automatic issue(input bit rd, input bit wr, input logic [7:0] a, input logic [7:0] d);
    core_state = REQ; rd_en = rd; wr_en = wr; rs = a; rt = d;
    step();
    check("issue_state_req", lsu_state, S_REQ);
    core_state = 3'b000; rd_en = 0; wr_en = 0; rs = 8'h00; rt = 8'h00;
    step();
  endtask

  // Measure one valid pulse on the chosen channel; ready is raised on valid cycle ready_on (0 = never).
  task automatic pulse(input bit wr, input int ready_on, input logic [7:0] ea, input logic [7:0] ed,
                       output int n);
    bit v, ended;
    n = 0; ended = 0;
    for (int i = 0; i < 40; i++) begin
      v = wr ? mem_write_valid : mem_read_valid;
      if (wr ? mem_read_valid : mem_write_valid) other_seen = 1;
      if (!v && n > 0) begin ended = 1; break; end
      if (v) begin
        n++;
        if (wr ? (mem_write_addr !== ea || mem_write_data !== ed) : (mem_read_addr !== ea)) chan_bad = 1;
        if (n == ready_on) begin
          if (wr) mem_write_ready = 1; else mem_read_ready = 1;
        end
      end
      step();
      mem_read_ready = 0; mem_write_ready = 0;
    end
    if (!ended) check("pulse_bound", 0, 1);
  endtask

  initial begin
    reset = 1; enable = 1; core_state = 0; rd_en = 0; wr_en = 0; rs = 0; rt = 0;
    mem_read_ready = 0; mem_read_data = 8'h00; mem_write_ready = 0;
    step(); step();
    reset = 0;
    step();
    check("rst_state", lsu_state, S_IDLE);
    check("rst_rvalid", mem_read_valid, 0);
    check("rst_wvalid", mem_write_valid, 0);
    check("rst_out", lsu_out, 8'h00);
    check("rst_err", lsu_error, 0);
    check("rst_retries", lsu_retries, 0);

    // Read, ready on third valid cycle.
    other_seen = 0; chan_bad = 0; mem_read_data = 8'h5C;
    issue(1, 0, 8'h2A, 8'h00);
    pulse(0, 3, 8'h2A, 8'h00, len);
    check("rd_len", len, 3);
    check("rd_addr_stable", chan_bad, 0);
    check("rd_no_wvalid", other_seen, 0);
    check("rd_state_done", lsu_state, S_DONE);
    check("rd_out", lsu_out, 8'h5C);
    core_state = UPD; step(); core_state = 0;
    check("rd_back_idle", lsu_state, S_IDLE);

    // Write, ready on second valid cycle; lsu_out untouched.
    other_seen = 0; chan_bad = 0; mem_read_data = 8'h11;
    issue(0, 1, 8'h10, 8'hF0);
    pulse(1, 2, 8'h10, 8'hF0, len);
    check("wr_len", len, 2);
    check("wr_addr_data_stable", chan_bad, 0);
    check("wr_no_rvalid", other_seen, 0);
    check("wr_state_done", lsu_state, S_DONE);
    check("wr_out_kept", lsu_out, 8'h5C);
    core_state = UPD; step(); core_state = 0;
    check("wr_back_idle", lsu_state, S_IDLE);

    // One timeout, then success on the re-issue.
    chan_bad = 0; mem_read_data = 8'hA7;
    issue(1, 0, 8'h33, 8'h00);
    pulse(0, 0, 8'h33, 8'h00, len);
    check("to_len", len, 16);
    check("to_gap_state", lsu_state, S_REQ);
    check("to_gap_valid", mem_read_valid, 0);
    check("to_retries", lsu_retries, 1);
    step();
    check("to_reassert", mem_read_valid, 1);
    pulse(0, 2, 8'h33, 8'h00, len);
    check("to_len2", len, 2);
    check("to_addr_stable", chan_bad, 0);
    check("to_state_done", lsu_state, S_DONE);
    check("to_err", lsu_error, 0);
    check("to_out", lsu_out, 8'hA7);
    core_state = UPD; step(); core_state = 0;
    check("to_retries_clr", lsu_retries, 0);

    // Exhaustion: three full-length pulses, then ERROR.
    mem_read_data = 8'hEE;
    issue(1, 0, 8'h44, 8'h00);
    for (int p = 0; p < 3; p++) begin
      pulse(0, 0, 8'h44, 8'h00, len);
      check("ex_len", len, 16);
      if (p < 2) begin
        check("ex_gap_state", lsu_state, S_REQ);
        check("ex_retries", lsu_retries, p + 1);
        step();
      end
    end
    check("ex_state_err", lsu_state, S_ERR);
    check("ex_err", lsu_error, 1);
    check("ex_retries_final", lsu_retries, 2);
    mem_read_ready = 1; step(); mem_read_ready = 0;
    check("ex_late_ready_state", lsu_state, S_ERR);
    check("ex_out_kept", lsu_out, 8'hA7);
    core_state = UPD; step(); core_state = 0;
    check("ex_idle", lsu_state, S_IDLE);
    check("ex_err_clr", lsu_error, 0);
    check("ex_retries_clr", lsu_retries, 0);

    // Ready on the expiry cycle wins.
    mem_read_data = 8'h3C;
    issue(1, 0, 8'h55, 8'h00);
    pulse(0, 16, 8'h55, 8'h00, len);
    check("bd_len", len, 16);
    check("bd_state_done", lsu_state, S_DONE);
    check("bd_retries", lsu_retries, 0);
    check("bd_out", lsu_out, 8'h3C);
    core_state = UPD; step(); core_state = 0;

    // Both enables: read only.
    other_seen = 0; chan_bad = 0; mem_read_data = 8'h99;
    issue(1, 1, 8'h66, 8'h77);
    pulse(0, 1, 8'h66, 8'h00, len);
    check("both_len", len, 1);
    check("both_no_wvalid", other_seen, 0);
    check("both_out", lsu_out, 8'h99);
    core_state = UPD; step(); core_state = 0;

    // Asynchronous reset in the fifth valid cycle.
    issue(1, 0, 8'h2A, 8'h00);
    step(); step(); step(); step();
    check("ar_valid_before", mem_read_valid, 1);
    reset = 1;
    #1;
    check("ar_valid", mem_read_valid, 0);
    check("ar_addr", mem_read_addr, 8'h00);
    check("ar_state", lsu_state, S_IDLE);
    check("ar_out", lsu_out, 8'h00);
    step();
    reset = 0;
    mem_read_ready = 1;
    step(); step(); step();
    mem_read_ready = 0;
    check("ar_late_state", lsu_state, S_IDLE);
    check("ar_late_valid", mem_read_valid, 0);
    check("ar_late_out", lsu_out, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
